alu_result_stage: RTL and testbench

Registered result stage directly downstream of the 8-bit ALU. It captures the ALU result, a destination register index and the C/V/N/Z flags through a valid/ready handshake. A 2-entry skid buffer means upstream never sees a combinational ready path from downstream. It also holds the architectural status register and evaluates branch conditions from it for the sequencer.

---
 rtl/alu_result_stage_if.sv | 33 +++
 rtl/alu_result_stage.sv | 108 ++++++++++
 tb/tb_alu_result_stage.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake/bus bundle between the ALU, the result stage and writeback.
// Signal names match the original flat port list.
interface alu_result_stage_if #(
  parameter int WIDTH = 8,
  parameter int DESTW = 3
);
  logic [WIDTH-1:0] Y;
  logic             C;
  logic             V;
  logic             N;
  logic             Z;
  logic [DESTW-1:0] IN_DEST;
  logic             IN_FLAGWE;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] OUT_DATA;
  logic [DESTW-1:0] OUT_DEST;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [2:0]       COND;
  logic             COND_TRUE;
  logic [3:0]       SR;

  modport master (
    output Y, C, V, N, Z, IN_DEST, IN_FLAGWE, IN_VALID, OUT_READY, COND,
    input  IN_READY, OUT_DATA, OUT_DEST, OUT_VALID, COND_TRUE, SR
  );

  modport slave (
    input  Y, C, V, N, Z, IN_DEST, IN_FLAGWE, IN_VALID, OUT_READY, COND,
    output IN_READY, OUT_DATA, OUT_DEST, OUT_VALID, COND_TRUE, SR
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: 2-entry skid buffer (main M, skid S) with
// registered IN_READY, plus the status register and branch-condition decode.
module alu_result_stage #(
  parameter int WIDTH = 8,
  parameter int DESTW = 3
) (
  input  logic             CLK,
  input  logic             RESET_N,
  alu_result_stage_if.slave bus
);

  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [DESTW-1:0] m_dest_q, m_dest_d;
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
  logic [DESTW-1:0] s_dest_q, s_dest_d;
  logic             s_valid_q, s_valid_d;
  logic [3:0]       sr_q, sr_d;
  logic             accept;
  logic             pop;
  logic             cond_true;

  assign accept = bus.IN_VALID & ~s_valid_q;
  assign pop    = m_valid_q & bus.OUT_READY;

  always_comb begin
    m_data_d  = m_data_q;
    m_dest_d  = m_dest_q;
    m_valid_d = m_valid_q;
    s_data_d  = s_data_q;
    s_dest_d  = s_dest_q;
    s_valid_d = s_valid_q;
    sr_d      = sr_q;

    if (!m_valid_q || pop) begin
      if (s_valid_q) begin
        m_data_d  = s_data_q;
        m_dest_d  = s_dest_q;
        m_valid_d = 1'b1;
        // accept is always 0 here (S full), kept for symmetry with the rule set
        if (accept) begin
          s_data_d = bus.Y;
          s_dest_d = bus.IN_DEST;
        end else begin
          s_valid_d = 1'b0;
        end
      end else if (accept) begin
        m_data_d  = bus.Y;
        m_dest_d  = bus.IN_DEST;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_data_d  = bus.Y;
      s_dest_d  = bus.IN_DEST;
      s_valid_d = 1'b1;
    end

    if (accept && bus.IN_FLAGWE) begin
      sr_d = {bus.N, bus.Z, bus.C, bus.V};
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_data_q  <= '0;
      m_dest_q  <= '0;
      m_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_dest_q  <= '0;
      s_valid_q <= 1'b0;
      sr_q      <= '0;
    end else begin
      m_data_q  <= m_data_d;
      m_dest_q  <= m_dest_d;
      m_valid_q <= m_valid_d;
      s_data_q  <= s_data_d;
      s_dest_q  <= s_dest_d;
      s_valid_q <= s_valid_d;
      sr_q      <= sr_d;
    end
  end

  // SR layout is {N,Z,C,V}
  always_comb begin
    cond_true = 1'b1;
    unique case (bus.COND)
      3'b000: cond_true = 1'b1;
      3'b001: cond_true = sr_q[2];
      3'b010: cond_true = ~sr_q[2];
      3'b011: cond_true = sr_q[1];
      3'b100: cond_true = ~sr_q[1];
      3'b101: cond_true = sr_q[3];
      3'b110: cond_true = sr_q[0];
      3'b111: cond_true = sr_q[3] ^ sr_q[0];
      default: cond_true = 1'b1;
    endcase
  end

  assign bus.IN_READY  = ~s_valid_q;
  assign bus.OUT_VALID = m_valid_q;
  assign bus.OUT_DATA  = m_data_q;
  assign bus.OUT_DEST  = m_dest_q;
  assign bus.SR        = sr_q;
  assign bus.COND_TRUE = cond_true;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed and random self-checking bench for alu_result_stage.
module tb_alu_result_stage;

  logic CLK;
  logic RESET_N;
  int   tests_run;
  int   tests_failed;

  alu_result_stage_if #(.WIDTH(8), .DESTW(3)) bus ();

  alu_result_stage #(.WIDTH(8), .DESTW(3)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic drive(input logic v, input logic [7:0] y, input logic [2:0] d,
                       input logic fwe, input logic [3:0] nzcv);
    bus.IN_VALID  = v;
    bus.Y         = y;
    bus.IN_DEST   = d;
    bus.IN_FLAGWE = fwe;
    {bus.N, bus.Z, bus.C, bus.V} = nzcv;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic exp_cond(input logic [3:0] sr, input logic [2:0] c);
    case (c)
      3'd0: return 1'b1;
      3'd1: return sr[2];
      3'd2: return !sr[2];
      3'd3: return sr[1];
      3'd4: return !sr[1];
      3'd5: return sr[3];
      3'd6: return sr[0];
      default: return sr[3] != sr[0];
    endcase
  endfunction

  task automatic test_reset();
    logic [7:0] cond_tab;
    cond_tab = 8'b0001_0101;
    RESET_N = 1'b0;
    bus.OUT_READY = 1'b1;
    bus.COND = 3'd0;
    drive(1'b1, 8'($urandom), 3'($urandom), 1'b1, 4'hF);
    repeat (3) tick();
    tests_run++;
    if (bus.OUT_VALID !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid got %b exp 0", bus.OUT_VALID);
    end
    tests_run++;
    if (bus.IN_READY !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready got %b exp 1", bus.IN_READY);
    end
    tests_run++;
    if (bus.SR !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_sr got %b exp 0000", bus.SR);
    end
    tests_run++;
    if (bus.OUT_DATA !== 8'h00 || bus.OUT_DEST !== 3'd0) begin
      tests_failed++; $display("FAIL reset_out_bus got %h/%0d exp 00/0", bus.OUT_DATA, bus.OUT_DEST);
    end
    for (int unsigned c = 0; c < 8; c++) begin
      bus.COND = 3'(c);
      #1;
      tests_run++;
      if (bus.COND_TRUE !== cond_tab[c]) begin
        tests_failed++;
        $display("FAIL reset_cond%0d got %b exp %b", c, bus.COND_TRUE, cond_tab[c]);
      end
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0, 4'h0);
    RESET_N = 1'b1;
    tick();
    tests_run++;
    if (bus.OUT_VALID !== 1'b0 || bus.SR !== 4'b0000) begin
      tests_failed++; $display("FAIL post_reset_idle got v=%b sr=%b exp v=0 sr=0000", bus.OUT_VALID, bus.SR);
    end
  endtask

  task automatic test_streaming();
    logic [7:0] ys [3];
    logic [2:0] ds [3];
    ys = '{8'h05, 8'h80, 8'h00};
    ds = '{3'd1, 3'd2, 3'd3};
    bus.OUT_READY = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b1, ys[i], ds[i], 1'b0, 4'h0);
      tests_run++;
      if (bus.IN_READY !== 1'b1) begin
        tests_failed++; $display("FAIL stream_ready%0d got %b exp 1", i, bus.IN_READY);
      end
      tick();
      tests_run++;
      if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== ys[i] || bus.OUT_DEST !== ds[i]) begin
        tests_failed++;
        $display("FAIL stream_out%0d got v=%b %h/%0d exp v=1 %h/%0d", i, bus.OUT_VALID,
                 bus.OUT_DATA, bus.OUT_DEST, ys[i], ds[i]);
      end
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0, 4'h0);
    tick();
    tests_run++;
    if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin
      tests_failed++; $display("FAIL stream_drain got v=%b r=%b exp v=0 r=1", bus.OUT_VALID, bus.IN_READY);
    end
  endtask

  task automatic test_back_pressure();
    bus.OUT_READY = 1'b0;
    drive(1'b1, 8'h11, 3'd4, 1'b0, 4'h0);
    tick();
    tests_run++;
    if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== 8'h11 || bus.IN_READY !== 1'b1) begin
      tests_failed++; $display("FAIL bp_first got v=%b d=%h r=%b exp v=1 d=11 r=1",
                               bus.OUT_VALID, bus.OUT_DATA, bus.IN_READY);
    end
    drive(1'b1, 8'h22, 3'd5, 1'b0, 4'h0);
    tick();
    tests_run++;
    if (bus.IN_READY !== 1'b0 || bus.OUT_DATA !== 8'h11) begin
      tests_failed++; $display("FAIL bp_full got r=%b d=%h exp r=0 d=11", bus.IN_READY, bus.OUT_DATA);
    end
    drive(1'b1, 8'h33, 3'd6, 1'b0, 4'h0);
    tick();
    tests_run++;
    if (bus.IN_READY !== 1'b0 || bus.OUT_DATA !== 8'h11 || bus.OUT_DEST !== 3'd4) begin
      tests_failed++; $display("FAIL bp_hold got r=%b d=%h/%0d exp r=0 d=11/4",
                               bus.IN_READY, bus.OUT_DATA, bus.OUT_DEST);
    end
    bus.OUT_READY = 1'b1;
    tick();
    tests_run++;
    if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== 8'h22 || bus.OUT_DEST !== 3'd5 || bus.IN_READY !== 1'b1) begin
      tests_failed++; $display("FAIL bp_pop1 got v=%b d=%h/%0d r=%b exp v=1 d=22/5 r=1",
                               bus.OUT_VALID, bus.OUT_DATA, bus.OUT_DEST, bus.IN_READY);
    end
    tick();
    tests_run++;
    if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== 8'h33 || bus.OUT_DEST !== 3'd6 || bus.IN_READY !== 1'b1) begin
      tests_failed++; $display("FAIL bp_pop2 got v=%b d=%h/%0d r=%b exp v=1 d=33/6 r=1",
                               bus.OUT_VALID, bus.OUT_DATA, bus.OUT_DEST, bus.IN_READY);
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0, 4'h0);
    tick();
    tests_run++;
    if (bus.OUT_VALID !== 1'b0) begin
      tests_failed++; $display("FAIL bp_no_dup got v=%b d=%h exp v=0", bus.OUT_VALID, bus.OUT_DATA);
    end
  endtask

  task automatic test_flags();
    bus.OUT_READY = 1'b1;
    drive(1'b1, 8'h00, 3'd1, 1'b1, 4'b0100);
    tick();
    tests_run++;
    if (bus.SR !== 4'b0100) begin
      tests_failed++; $display("FAIL flags_z got %b exp 0100", bus.SR);
    end
    bus.COND = 3'd1; #1;
    tests_run++;
    if (bus.COND_TRUE !== 1'b1) begin
      tests_failed++; $display("FAIL flags_eq got %b exp 1", bus.COND_TRUE);
    end
    bus.COND = 3'd2; #1;
    tests_run++;
    if (bus.COND_TRUE !== 1'b0) begin
      tests_failed++; $display("FAIL flags_ne got %b exp 0", bus.COND_TRUE);
    end
    drive(1'b1, 8'h07, 3'd2, 1'b0, 4'b1011);
    tick();
    tests_run++;
    if (bus.SR !== 4'b0100) begin
      tests_failed++; $display("FAIL flags_nowe got %b exp 0100", bus.SR);
    end
    drive(1'b1, 8'h90, 3'd3, 1'b1, 4'b1000);
    tick();
    tests_run++;
    if (bus.SR !== 4'b1000) begin
      tests_failed++; $display("FAIL flags_n got %b exp 1000", bus.SR);
    end
    bus.COND = 3'd7; #1;
    tests_run++;
    if (bus.COND_TRUE !== 1'b1) begin
      tests_failed++; $display("FAIL flags_lt got %b exp 1", bus.COND_TRUE);
    end
    bus.COND = 3'd5; #1;
    tests_run++;
    if (bus.COND_TRUE !== 1'b1) begin
      tests_failed++; $display("FAIL flags_mi got %b exp 1", bus.COND_TRUE);
    end
    drive(1'b1, 8'h80, 3'd4, 1'b1, 4'b0011);
    tick();
    bus.COND = 3'd3; #1;
    tests_run++;
    if (bus.SR !== 4'b0011 || bus.COND_TRUE !== 1'b1) begin
      tests_failed++; $display("FAIL flags_cs got sr=%b ct=%b exp sr=0011 ct=1", bus.SR, bus.COND_TRUE);
    end
    bus.COND = 3'd4; #1;
    tests_run++;
    if (bus.COND_TRUE !== 1'b0) begin
      tests_failed++; $display("FAIL flags_cc got %b exp 0", bus.COND_TRUE);
    end
    bus.COND = 3'd6; #1;
    tests_run++;
    if (bus.COND_TRUE !== 1'b1) begin
      tests_failed++; $display("FAIL flags_vs got %b exp 1", bus.COND_TRUE);
    end
    bus.COND = 3'd7; #1;
    tests_run++;
    if (bus.COND_TRUE !== 1'b1) begin
      tests_failed++; $display("FAIL flags_lt_v got %b exp 1", bus.COND_TRUE);
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0, 4'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    bus.OUT_READY = 1'b0;
    drive(1'b1, 8'hA1, 3'd1, 1'b1, 4'b1010);
    tick();
    drive(1'b1, 8'hA2, 3'd2, 1'b0, 4'b0000);
    tick();
    tests_run++;
    if (bus.OUT_VALID !== 1'b1 || bus.IN_READY !== 1'b0 || bus.SR !== 4'b1010) begin
      tests_failed++; $display("FAIL mid_fill got v=%b r=%b sr=%b exp v=1 r=0 sr=1010",
                               bus.OUT_VALID, bus.IN_READY, bus.SR);
    end
    #2 RESET_N = 1'b0;
    #1;
    tests_run++;
    if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1 || bus.SR !== 4'b0000 || bus.OUT_DATA !== 8'h00) begin
      tests_failed++; $display("FAIL mid_async got v=%b r=%b sr=%b d=%h exp v=0 r=1 sr=0000 d=00",
                               bus.OUT_VALID, bus.IN_READY, bus.SR, bus.OUT_DATA);
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0, 4'h0);
    tick();
    RESET_N = 1'b1;
    bus.OUT_READY = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (bus.OUT_VALID !== 1'b0) begin
        tests_failed++; $display("FAIL mid_stale%0d got v=%b d=%h exp v=0", i, bus.OUT_VALID, bus.OUT_DATA);
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] q [$];
    logic [3:0]  sr_m;
    logic        v, fwe, acc, pop_m;
    logic [7:0]  y;
    logic [2:0]  d;
    logic [3:0]  f;
    RESET_N = 1'b0;
    drive(1'b0, 8'h00, 3'd0, 1'b0, 4'h0);
    tick();
    RESET_N = 1'b1;
    sr_m = 4'b0000;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tests_run++;
      if (bus.IN_READY !== (q.size() < 2) || bus.OUT_VALID !== (q.size() > 0)) begin
        tests_failed++; $display("FAIL rnd_occ cyc %0d got r=%b v=%b exp occupancy %0d",
                                 cyc, bus.IN_READY, bus.OUT_VALID, q.size());
      end
      if (q.size() > 0) begin
        tests_run++;
        if ({bus.OUT_DATA, bus.OUT_DEST} !== q[0]) begin
          tests_failed++; $display("FAIL rnd_data cyc %0d got %h/%0d exp %h/%0d",
                                   cyc, bus.OUT_DATA, bus.OUT_DEST, q[0][10:3], q[0][2:0]);
        end
      end
      tests_run++;
      if (bus.SR !== sr_m) begin
        tests_failed++; $display("FAIL rnd_sr cyc %0d got %b exp %b", cyc, bus.SR, sr_m);
      end
      v   = 1'($urandom_range(0, 1));
      y   = 8'($urandom);
      d   = 3'($urandom);
      fwe = 1'($urandom_range(0, 1));
      f   = 4'($urandom);
      drive(v, y, d, fwe, f);
      bus.OUT_READY = ($urandom_range(0, 2) != 0);
      bus.COND = 3'($urandom);
      #1;
      tests_run++;
      if (bus.COND_TRUE !== exp_cond(sr_m, bus.COND)) begin
        tests_failed++; $display("FAIL rnd_cond cyc %0d got %b exp %b",
                                 cyc, bus.COND_TRUE, exp_cond(sr_m, bus.COND));
      end
      acc   = v && (q.size() < 2);
      pop_m = (q.size() > 0) && bus.OUT_READY;
      tick();
      if (pop_m) void'(q.pop_front());
      if (acc) q.push_back({y, d});
      if (acc && fwe) sr_m = f;
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0, 4'h0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    RESET_N      = 1'b0;
    bus.COND     = 3'd0;
    bus.OUT_READY = 1'b0;
    drive(1'b0, 8'h00, 3'd0, 1'b0, 4'h0);
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flags();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
